// File: rtl/mips150_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module : mips150_mem_arbiter
// Desc   : Shares one single-port synchronous block RAM between the MIPS150
//          instruction-fetch port and the load/store data port.
// Rev    : 1.0  initial release
//============================================================================
module mips150_mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int LAT          = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch port
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    // load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_misalign,
    // block RAM
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam int              c_SCW        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SCW-1:0] c_STARVE_MAX = c_SCW'(STARVE_LIMIT);
    localparam logic [2:0]      c_LAT_LOAD   = 3'(LAT - 1);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_lat_cnt;
    logic [2:0]        w_lat_nxt;
    logic [c_SCW-1:0]  r_starve;
    logic [c_SCW-1:0]  w_starve_nxt;
    logic              r_owner_d;
    logic              w_owner_nxt;

    logic              w_arb_ok;
    logic              w_rd_done;
    logic              w_starved;
    logic              w_d_win;
    logic              w_i_win;
    logic              w_misalign;
    logic              w_d_mem;
    logic              w_rd_issue;
    logic              w_st_issue;
    logic [3:0]        w_st_we;
    logic [31:0]       w_st_data;
    logic              w_unused;

    // The cycle that returns read data is also an arbitration cycle.
    // Gating with rst keeps the combinational grants quiet during reset.
    assign w_rd_done = (r_state == ST_RD_WAIT) && (r_lat_cnt == 3'd0);
    assign w_arb_ok  = !rst && ((r_state == ST_IDLE) || w_rd_done);
    assign w_starved = (r_starve == c_STARVE_MAX);

    assign w_d_win    = w_arb_ok && d_req && (!w_starved || !i_req);
    assign w_i_win    = w_arb_ok && i_req && !w_d_win;
    assign w_d_mem    = w_d_win && !w_misalign;
    assign w_rd_issue = w_i_win || (w_d_mem && !d_we);
    assign w_st_issue = w_d_mem && d_we;

    always_comb begin
        w_misalign = 1'b0;
        case (d_size)
            c_SZ_BYTE: w_misalign = 1'b0;
            c_SZ_HALF: w_misalign = d_addr[0];
            c_SZ_WORD: w_misalign = |d_addr[1:0];
            default:   w_misalign = 1'b1;
        endcase
    end

    always_comb begin
        w_st_we   = 4'b0000;
        w_st_data = d_wdata;
        case (d_size)
            c_SZ_BYTE: begin
                w_st_we   = 4'b0001 << d_addr[1:0];
                w_st_data = {4{d_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_st_we   = 4'b0011 << {d_addr[1], 1'b0};
                w_st_data = {2{d_wdata[15:0]}};
            end
            c_SZ_WORD: begin
                w_st_we   = 4'b1111;
                w_st_data = d_wdata;
            end
            default: begin
                w_st_we   = 4'b0000;
                w_st_data = d_wdata;
            end
        endcase
    end

    // Next-state, latency countdown, read owner and fetch starvation tracking
    always_comb begin
        w_state_nxt  = r_state;
        w_lat_nxt    = r_lat_cnt;
        w_owner_nxt  = r_owner_d;
        w_starve_nxt = r_starve;

        case (r_state)
            ST_IDLE: begin
                if (w_rd_issue) begin
                    w_state_nxt = ST_RD_WAIT;
                    w_lat_nxt   = c_LAT_LOAD;
                end
            end
            ST_RD_WAIT: begin
                if (r_lat_cnt != 3'd0) begin
                    w_lat_nxt = r_lat_cnt - 3'd1;
                end else if (w_rd_issue) begin
                    w_state_nxt = ST_RD_WAIT;
                    w_lat_nxt   = c_LAT_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_lat_nxt   = 3'd0;
            end
        endcase

        if (w_rd_issue) begin
            w_owner_nxt = w_d_mem;
        end

        if (w_i_win) begin
            w_starve_nxt = '0;
        end else if (i_req && !w_starved) begin
            w_starve_nxt = r_starve + c_SCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_lat_cnt <= 3'd0;
            r_owner_d <= 1'b0;
            r_starve  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_nxt;
            r_owner_d <= w_owner_nxt;
            r_starve  <= w_starve_nxt;
        end
    end

    assign i_gnt      = w_i_win;
    assign d_gnt      = w_d_win;
    assign d_misalign = w_d_win && w_misalign;

    assign mem_en    = w_i_win || w_d_mem;
    assign mem_we    = w_st_issue ? w_st_we : 4'b0000;
    assign mem_wdata = w_st_issue ? w_st_data : 32'd0;
    assign mem_addr  = w_i_win ? i_addr[ADDR_W+1:2] :
                       w_d_mem ? d_addr[ADDR_W+1:2] : '0;

    assign busy = (r_state == ST_RD_WAIT) && (r_lat_cnt != 3'd0);

    assign i_rvalid = w_rd_done && !r_owner_d;
    assign d_rvalid = w_rd_done && r_owner_d;
    assign i_rdata  = i_rvalid ? mem_rdata : 32'd0;
    assign d_rdata  = d_rvalid ? mem_rdata : 32'd0;

    assign w_unused = ^{i_addr[1:0], i_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

endmodule
`default_nettype wire

// File: tb/tb_mips150_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module : tb_mips150_mem_arbiter
// Desc   : Directed and randomized checks of mips150_mem_arbiter at LAT=1
//          (instance 0) and LAT=3 (instance 1) against a cycle-budget model.
// Rev    : 1.0  initial release
//============================================================================
module tb_mips150_mem_arbiter;

    localparam int c_NK      = 2;
    localparam int c_LIMIT   = 4;
    localparam int c_RND_CYC = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req      [c_NK];
    logic [31:0] i_addr     [c_NK];
    logic        i_gnt      [c_NK];
    logic        i_rvalid   [c_NK];
    logic [31:0] i_rdata    [c_NK];
    logic        d_req      [c_NK];
    logic        d_we       [c_NK];
    logic [1:0]  d_size     [c_NK];
    logic [31:0] d_addr     [c_NK];
    logic [31:0] d_wdata    [c_NK];
    logic        d_gnt      [c_NK];
    logic        d_rvalid   [c_NK];
    logic [31:0] d_rdata    [c_NK];
    logic        d_misalign [c_NK];
    logic        mem_en     [c_NK];
    logic [3:0]  mem_we     [c_NK];
    logic [11:0] mem_addr   [c_NK];
    logic [31:0] mem_wdata  [c_NK];
    logic [31:0] mem_rdata  [c_NK];
    logic        busy       [c_NK];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_NK; g++) begin : g_dut
        mips150_mem_arbiter #(
            .ADDR_W      (12),
            .LAT         ((g == 0) ? 1 : 3),
            .STARVE_LIMIT(c_LIMIT)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .i_req     (i_req[g]),
            .i_addr    (i_addr[g]),
            .i_gnt     (i_gnt[g]),
            .i_rvalid  (i_rvalid[g]),
            .i_rdata   (i_rdata[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_size    (d_size[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .d_misalign(d_misalign[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );
    end

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Unwritten memory words hold a deterministic pattern per instance.
    function automatic logic [31:0] init_word(int k, int a);
        return (32'(a) * 32'h9E37_79B1) ^ ((k == 0) ? 32'h5A5A_0F0F : 32'hC3C3_1234);
    endfunction

    // Block RAM stand-in driven by the DUT memory outputs.
    logic [31:0] env_mem [c_NK][4096];
    bit          env_wr  [c_NK][4096];
    logic [31:0] rd_pipe [c_NK][4];

    always @(posedge clk) begin
        for (int k = 0; k < c_NK; k++) begin
            automatic logic [31:0] cur;
            cur = env_wr[k][mem_addr[k]] ? env_mem[k][mem_addr[k]] : init_word(k, int'(mem_addr[k]));
            for (int j = 3; j > 0; j--) rd_pipe[k][j] <= rd_pipe[k][j-1];
            rd_pipe[k][0] <= (mem_en[k] && mem_we[k] == 4'd0) ? cur : (32'hBADC_0DE0 ^ 32'(k));
            if (mem_en[k] && mem_we[k] != 4'd0) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[k][b]) cur[8*b +: 8] = mem_wdata[k][8*b +: 8];
                env_mem[k][mem_addr[k]] <= cur;
                env_wr[k][mem_addr[k]]  <= 1'b1;
            end
        end
    end

    assign mem_rdata[0] = rd_pipe[0][0];
    assign mem_rdata[1] = rd_pipe[1][2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < c_NK; k++) begin
            i_req[k] = 1'b0; i_addr[k] = 32'd0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_size[k] = 2'b00;
            d_addr[k] = 32'd0; d_wdata[k] = 32'd0;
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_d(input int k, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        d_req[k] = 1'b1; d_we[k] = we; d_size[k] = sz; d_addr[k] = a; d_wdata[k] = wd;
    endtask

    task automatic check_quiet(input string tag, input int k);
        check_val(tag, {i_gnt[k], d_gnt[k], i_rvalid[k], d_rvalid[k], d_misalign[k],
                        mem_en[k], busy[k], mem_we[k], mem_addr[k]}, 64'd0);
        check_val({tag, "_data"}, {i_rdata[k], d_rdata[k]}, 64'd0);
        check_val({tag, "_wdata"}, {32'd0, mem_wdata[k]}, 64'd0);
    endtask

    // ---------------- reference model (cycle-budget level) ----------------
    logic [31:0] ref_mem [c_NK][4096];
    bit          ref_wr  [c_NK][4096];
    int          cyc;
    int          blk     [c_NK];
    int          stv     [c_NK];
    bit          pv      [c_NK];
    int          pdue    [c_NK];
    bit          pd      [c_NK];
    logic [31:0] pdata   [c_NK];
    bit          i_hold  [c_NK];
    bit          d_hold  [c_NK];

    function automatic logic [31:0] ref_rd(int k, int a);
        return ref_wr[k][a] ? ref_mem[k][a] : init_word(k, a);
    endfunction

    function automatic bit misal(logic [1:0] sz, logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    task automatic lanes(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         output logic [3:0] we, output logic [31:0] data);
        int off;
        off = int'(a[1:0]);
        case (sz)
            2'b00: begin we = 4'(1 << off); data = {4{wd[7:0]}}; end
            2'b01: begin we = a[1] ? 4'b1100 : 4'b0011; data = {2{wd[15:0]}}; end
            default: begin we = 4'b1111; data = wd; end
        endcase
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        return (r & 32'hFFFF_C000) | (32'h100 + 32'($urandom_range(0, 255)));
    endfunction

    task automatic model_cycle(input int k);
        bit can, starved, dwin, iwin, mis, rd, st, erv_i, erv_d;
        logic [3:0]  ewe;
        logic [31:0] ewd;
        int          ea;
        string       tg;
        tg      = $sformatf("rnd k%0d c%0d", k, cyc);
        can     = (cyc >= blk[k]);
        starved = (stv[k] >= c_LIMIT);
        dwin    = can && d_req[k] && (!starved || !i_req[k]);
        iwin    = can && i_req[k] && !dwin;
        mis     = dwin && misal(d_size[k], d_addr[k]);
        st      = dwin && !mis && d_we[k];
        rd      = iwin || (dwin && !mis && !d_we[k]);
        ea      = iwin ? int'(i_addr[k][13:2]) : int'(d_addr[k][13:2]);
        ewe     = 4'd0;
        ewd     = 32'd0;
        if (st) lanes(d_size[k], d_addr[k], d_wdata[k], ewe, ewd);
        erv_i = pv[k] && pdue[k] == cyc && !pd[k];
        erv_d = pv[k] && pdue[k] == cyc && pd[k];

        check_val({tg, " ctl"},
                  {i_gnt[k], d_gnt[k], d_misalign[k], mem_en[k], mem_we[k], busy[k], i_rvalid[k], d_rvalid[k]},
                  {iwin, dwin, mis, (iwin || (dwin && !mis)), ewe, !can, erv_i, erv_d});
        if (iwin || (dwin && !mis)) check_val({tg, " addr"}, 64'(mem_addr[k]), 64'(ea));
        if (st)    check_val({tg, " wdata"}, 64'(mem_wdata[k]), 64'(ewd));
        if (erv_i) check_val({tg, " i_rdata"}, 64'(i_rdata[k]), 64'(pdata[k]));
        if (erv_d) check_val({tg, " d_rdata"}, 64'(d_rdata[k]), 64'(pdata[k]));

        if (pv[k] && pdue[k] == cyc) pv[k] = 1'b0;
        if (rd) begin
            pv[k] = 1'b1; pdue[k] = cyc + lat_of(k); pd[k] = !iwin;
            pdata[k] = ref_rd(k, ea); blk[k] = cyc + lat_of(k);
        end
        if (st) begin
            ref_mem[k][ea] = ref_rd(k, ea);
            for (int b = 0; b < 4; b++)
                if (ewe[b]) ref_mem[k][ea][8*b +: 8] = ewd[8*b +: 8];
            ref_wr[k][ea] = 1'b1;
        end
        if (iwin) stv[k] = 0;
        else if (i_req[k] && stv[k] < c_LIMIT) stv[k]++;
        i_hold[k] = i_req[k] && !iwin;
        d_hold[k] = d_req[k] && !dwin;
    endtask

    initial begin
        logic [31:0] w8;
        w8 = init_word(0, 8);

        // Reset with requests pending: every output stays low
        idle_all();
        rst = 1'b1;
        i_req[0] = 1'b1;
        set_d(1, 1'b1, 2'b10, 32'h40, 32'h1);
        repeat (2) @(posedge clk);
        settle();
        for (int k = 0; k < c_NK; k++) check_quiet($sformatf("reset k%0d", k), k);
        next_cyc();
        rst = 1'b0;
        idle_all();

        // Word store then word load on LAT=1
        set_d(0, 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF);
        settle();
        check_val("st_word ctl", {d_gnt[0], mem_en[0], mem_we[0], mem_addr[0]}, {1'b1, 1'b1, 4'hF, 12'd4});
        check_val("st_word wdata", 64'(mem_wdata[0]), 64'hDEAD_BEEF);
        next_cyc();
        d_we[0] = 1'b0;
        settle();
        check_val("ld_word ctl", {d_gnt[0], mem_en[0], mem_we[0], mem_addr[0], busy[0]},
                  {1'b1, 1'b1, 4'h0, 12'd4, 1'b0});
        next_cyc();
        d_req[0] = 1'b0;
        settle();
        check_val("ld_word rv", {d_rvalid[0], i_rvalid[0], busy[0]}, 3'b100);
        check_val("ld_word data", 64'(d_rdata[0]), 64'hDEAD_BEEF);

        // Byte and half stores, read back the merged word
        next_cyc();
        set_d(0, 1'b1, 2'b00, 32'h23, 32'h0000_00AB);
        settle();
        check_val("st_byte ctl", {d_gnt[0], d_misalign[0], mem_en[0], mem_we[0], mem_addr[0]},
                  {1'b1, 1'b0, 1'b1, 4'b1000, 12'd8});
        check_val("st_byte wdata", 64'(mem_wdata[0]), 64'hABAB_ABAB);
        next_cyc();
        set_d(0, 1'b1, 2'b01, 32'h22, 32'h0000_1234);
        settle();
        check_val("st_half ctl", {d_gnt[0], mem_en[0], mem_we[0]}, {1'b1, 1'b1, 4'b1100});
        check_val("st_half wdata", 64'(mem_wdata[0]), 64'h1234_1234);
        next_cyc();
        set_d(0, 1'b0, 2'b10, 32'h20, 32'h0);
        settle();
        check_val("ld_merge gnt", {d_gnt[0], mem_en[0]}, 2'b11);
        next_cyc();
        set_d(0, 1'b1, 2'b01, 32'h1, 32'h5555);
        settle();
        check_val("ld_merge data", {d_rvalid[0], d_rdata[0]}, {1'b1, 16'h1234, w8[15:0]});
        check_val("mis_half", {d_gnt[0], d_misalign[0], mem_en[0], mem_we[0]}, {1'b1, 1'b1, 1'b0, 4'h0});
        next_cyc();
        set_d(0, 1'b0, 2'b10, 32'h6, 32'h0);
        settle();
        check_val("mis_word", {d_gnt[0], d_misalign[0], mem_en[0], mem_we[0]}, {1'b1, 1'b1, 1'b0, 4'h0});
        next_cyc();
        d_req[0] = 1'b0;
        settle();
        check_val("mis_no_rv", {d_rvalid[0], busy[0]}, 2'b00);

        // Starvation guard: four data wins, then fetch, then the count restarts
        next_cyc();
        set_d(0, 1'b1, 2'b10, 32'h40, 32'h11);
        i_req[0] = 1'b1; i_addr[0] = 32'h80;
        for (int n = 0; n < 4; n++) begin
            settle();
            check_val($sformatf("starve d%0d", n), {i_gnt[0], d_gnt[0]}, 2'b01);
            next_cyc();
        end
        settle();
        check_val("starve fetch", {i_gnt[0], d_gnt[0], mem_we[0], mem_addr[0]}, {1'b1, 1'b0, 4'h0, 12'd32});
        next_cyc();
        for (int n = 0; n < 4; n++) begin
            settle();
            check_val($sformatf("restart d%0d", n), {i_gnt[0], d_gnt[0]}, 2'b01);
            if (n == 0) check_val("starve i_rdata", {i_rvalid[0], i_rdata[0]}, {1'b1, init_word(0, 32)});
            next_cyc();
        end
        settle();
        check_val("restart fetch", {i_gnt[0], d_gnt[0]}, 2'b10);
        next_cyc();
        idle_all();

        // LAT=3: fetch read, data request waits while busy
        next_cyc();
        i_req[1] = 1'b1; i_addr[1] = 32'h100;
        settle();
        check_val("l3 fetch", {i_gnt[1], mem_en[1], mem_we[1], busy[1], mem_addr[1]},
                  {1'b1, 1'b1, 4'h0, 1'b0, 12'h40});
        next_cyc();
        i_req[1] = 1'b0;
        set_d(1, 1'b0, 2'b10, 32'h20, 32'h0);
        for (int n = 1; n <= 2; n++) begin
            settle();
            check_val($sformatf("l3 wait%0d", n), {busy[1], d_gnt[1], mem_en[1], i_rvalid[1]}, 4'b1000);
            next_cyc();
        end
        settle();
        check_val("l3 rv+gnt", {busy[1], d_gnt[1], mem_en[1], i_rvalid[1]}, 4'b0111);
        check_val("l3 i_rdata", 64'(i_rdata[1]), 64'(init_word(1, 64)));
        next_cyc();
        d_req[1] = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            settle();
            check_val($sformatf("l3 dbusy%0d", n), {busy[1], d_rvalid[1]}, 2'b10);
            next_cyc();
        end
        settle();
        check_val("l3 d_rv", {busy[1], d_rvalid[1], d_rdata[1]}, {1'b0, 1'b1, init_word(1, 8)});

        // LAT=3: reset during an outstanding read drops it
        next_cyc();
        i_req[1] = 1'b1; i_addr[1] = 32'h104;
        settle();
        check_val("rst_rd gnt", {i_gnt[1], mem_en[1]}, 2'b11);
        next_cyc();
        rst = 1'b1;
        settle();
        check_quiet("rst_mid", 1);
        next_cyc();
        rst = 1'b0;
        i_req[1] = 1'b0;
        settle();
        check_val("rst_mid t2", {i_rvalid[1], busy[1]}, 2'b00);
        next_cyc();
        settle();
        check_val("rst_mid t3", {i_rvalid[1], busy[1]}, 2'b00);
        next_cyc();
        i_req[1] = 1'b1;
        settle();
        check_val("rst_mid regrant", {i_gnt[1], mem_en[1], mem_addr[1]}, {1'b1, 1'b1, 12'h41});
        next_cyc();
        i_req[1] = 1'b0;
        repeat (2) next_cyc();
        settle();
        check_val("rst_mid rv", {i_rvalid[1], i_rdata[1]}, {1'b1, init_word(1, 65)});

        // Randomized traffic against the reference model
        next_cyc();
        idle_all();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        cyc = 0;
        for (int k = 0; k < c_NK; k++) begin
            blk[k] = 0; stv[k] = 0; pv[k] = 1'b0; i_hold[k] = 1'b0; d_hold[k] = 1'b0;
        end
        for (int c = 0; c < c_RND_CYC; c++) begin
            for (int k = 0; k < c_NK; k++) begin
                if (!i_hold[k]) begin
                    i_req[k]  = ($urandom_range(0, 2) != 0);
                    i_addr[k] = rand_addr();
                end
                if (!d_hold[k]) begin
                    d_req[k]   = ($urandom_range(0, 2) != 0);
                    d_we[k]    = 1'($urandom_range(0, 1));
                    d_size[k]  = 2'($urandom_range(0, 3));
                    d_addr[k]  = rand_addr();
                    d_wdata[k] = $urandom;
                end
            end
            settle();
            for (int k = 0; k < c_NK; k++) model_cycle(k);
            next_cyc();
            cyc++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
